// File: rtl/branch_resolve_unit.sv
// EX-stage branch/JLR resolver: registered redirect pulses, multi-cycle front-end flush.
// Optional 2-bit BHT prediction for fetch, enabled by defining BRANCH_PREDICT_EN.
module branch_resolve_unit #(
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       OPC_W        = 4,
  parameter logic [OPC_W-1:0]  OPC_BEQ      = OPC_W'(4'b1100),
  parameter logic [OPC_W-1:0]  OPC_JLR      = OPC_W'(4'b1001),
  parameter int unsigned       BHT_DEPTH    = 16,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic              ex_pred_taken,
  input  logic [DATA_W-1:0] if_pc,
  output logic              pred_taken,
  output logic              is_taken,
  output logic              is_jlr,
  output logic              fix_nt,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              mispredict,
  output logic              flush
);

  localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_taken_q, is_taken_d;
  logic              is_jlr_q, is_jlr_d;
  logic              fix_nt_q, fix_nt_d;
  logic              mispredict_q, mispredict_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

  logic accept, beq_acc, jlr_acc, actual, pred_eff;
  logic unused_c;

  assign unused_c = ^{ex_pred_taken, if_pc};

`ifdef BRANCH_PREDICT_EN
  assign pred_eff = ex_pred_taken;
`else
  assign pred_eff = 1'b0;
`endif

  // Resolve the EX instruction and compute next FSM state and pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;

    accept  = ex_valid && (state_q == ST_IDLE);
    beq_acc = accept && (opcode == OPC_BEQ);
    jlr_acc = accept && (opcode == OPC_JLR);
    actual  = (ALU_out == '0);

    is_jlr_d     = jlr_acc;
    is_taken_d   = beq_acc && actual && !pred_eff;
    fix_nt_d     = beq_acc && !actual && pred_eff;
    mispredict_d = is_taken_d || fix_nt_d;

    case (state_q)
      ST_IDLE: begin
        if (jlr_acc || mispredict_d) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    flush_d = (state_d == ST_FLUSH);
    if (fix_nt_d) redirect_pc_d = ex_pc + DATA_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      is_taken_q    <= 1'b0;
      is_jlr_q      <= 1'b0;
      fix_nt_q      <= 1'b0;
      mispredict_q  <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_taken_q    <= is_taken_d;
      is_jlr_q      <= is_jlr_d;
      fix_nt_q      <= fix_nt_d;
      mispredict_q  <= mispredict_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign is_taken    = is_taken_q;
  assign is_jlr      = is_jlr_q;
  assign fix_nt      = fix_nt_q;
  assign mispredict  = mispredict_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_PREDICT_EN
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] wr_idx;

  assign wr_idx = ex_pc[IDX_W-1:0];

  // Saturating 2-bit counters; reads see the pre-update value (no bypass).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= 2'b01;
    end else if (beq_acc) begin
      if (actual && (bht_q[wr_idx] != 2'b11))
        bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
      else if (!actual && (bht_q[wr_idx] != 2'b00))
        bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
    end
  end

  assign pred_taken = bht_q[if_pc[IDX_W-1:0]][1];
`else
  assign pred_taken = 1'b0;
`endif

endmodule
